// File: rtl/if_fetch_if.sv
// if_fetch_if
// Bundles the instruction-memory and fetch-to-decode signals of the fetch
// stage, together with its control-flow inputs.
//   master : fetch unit side (drives imem_addr and the id_* head/misalign outputs)
//   slave  : surrounding pipeline / memory side
// Signals:
//   imem_addr   fetch address (current PC)
//   imem_inst   combinational instruction for imem_addr
//   redirect    branch/jump taken, with target redirect_pc
//   exc         exception/interrupt taken (handler at EXC_VECTOR)
//   eret        return from exception, to epc
//   id_valid    head of the fetch buffer is valid
//   id_ready    decode consumes the head this cycle
//   id_inst     head instruction
//   id_pc       head address
//   id_pc4      head address + 4
//   misalign    misaligned control-flow target seen
interface if_fetch_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        exc;
  logic        eret;
  logic [31:0] epc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic        misalign;

  modport master (
    output imem_addr, id_valid, id_inst, id_pc, id_pc4, misalign,
    input  imem_inst, redirect, redirect_pc, exc, eret, epc, id_ready
  );

  modport slave (
    input  imem_addr, id_valid, id_inst, id_pc, id_pc4, misalign,
    output imem_inst, redirect, redirect_pc, exc, eret, epc, id_ready
  );
endinterface

// File: rtl/if_fetch.sv
// if_fetch
// Instruction fetch stage: a PC register feeding a combinational instruction
// memory and a 2-entry {pc, inst} buffer towards decode. Control-flow changes
// (exc > eret > redirect) flush the buffer and load the new PC; the target is
// fetched on the following cycle.
// Ports:
//   clk   rising-edge clock
//   clrn  asynchronous active-low reset
//   bus   if_fetch_if.master (memory, control-flow and decode handshake)
// Parameters:
//   RESET_PC    first fetch address after reset
//   EXC_VECTOR  exception handler entry address
// Build option:
//   IF_FETCH_ALIGN_CHECK_EN  when defined, a target with bits [1:0] != 0 sets
//   misalign and stalls fetching until an aligned control-flow change; when
//   undefined, target bits [1:0] are forced to zero and misalign is tied low.
module if_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0008
) (
  input logic        clk,
  input logic        clrn,
  if_fetch_if.master bus
);

  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] head_pc_q, head_pc_d, head_inst_q, head_inst_d;
  logic [31:0] tail_pc_q, tail_pc_d, tail_inst_q, tail_inst_d;

  logic        cf_change;
  logic [31:0] target_raw, target;
  logic        fetch_block;
  logic        deq, enq;
  logic [1:0]  remain;

`ifdef IF_FETCH_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;
`endif

  always_comb begin
    cf_change  = bus.exc | bus.eret | bus.redirect;
    target_raw = bus.exc  ? EXC_VECTOR :
                 bus.eret ? bus.epc    : bus.redirect_pc;
`ifdef IF_FETCH_ALIGN_CHECK_EN
    target      = target_raw;
    fetch_block = misalign_q;
`else
    target      = target_raw & ~32'h3;
    fetch_block = 1'b0;
`endif

    deq    = (count_q != 2'd0) && bus.id_ready;
    // A full buffer can still accept a fetch when the head leaves this cycle.
    enq    = !fetch_block && ((count_q != 2'd2) || deq);
    remain = count_q - {1'b0, deq};

    pc_d        = pc_q;
    count_d     = count_q;
    head_pc_d   = head_pc_q;
    head_inst_d = head_inst_q;
    tail_pc_d   = tail_pc_q;
    tail_inst_d = tail_inst_q;
`ifdef IF_FETCH_ALIGN_CHECK_EN
    misalign_d  = misalign_q;
`endif

    if (cf_change) begin
      // Fetch and dequeue of this cycle are both dropped.
      pc_d    = target;
      count_d = 2'd0;
`ifdef IF_FETCH_ALIGN_CHECK_EN
      misalign_d = (target[1:0] != 2'b00);
`endif
    end else begin
      if (deq) begin
        head_pc_d   = tail_pc_q;
        head_inst_d = tail_inst_q;
      end
      if (enq) begin
        if (remain == 2'd0) begin
          head_pc_d   = pc_q;
          head_inst_d = bus.imem_inst;
        end else begin
          tail_pc_d   = pc_q;
          tail_inst_d = bus.imem_inst;
        end
        pc_d = pc_q + 32'd4;
      end
      count_d = remain + {1'b0, enq};
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pc_q        <= RESET_PC;
      count_q     <= 2'd0;
      head_pc_q   <= 32'd0;
      head_inst_q <= 32'd0;
      tail_pc_q   <= 32'd0;
      tail_inst_q <= 32'd0;
`ifdef IF_FETCH_ALIGN_CHECK_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      pc_q        <= pc_d;
      count_q     <= count_d;
      head_pc_q   <= head_pc_d;
      head_inst_q <= head_inst_d;
      tail_pc_q   <= tail_pc_d;
      tail_inst_q <= tail_inst_d;
`ifdef IF_FETCH_ALIGN_CHECK_EN
      misalign_q  <= misalign_d;
`endif
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.id_valid  = (count_q != 2'd0);
  assign bus.id_inst   = head_inst_q;
  assign bus.id_pc     = head_pc_q;
  assign bus.id_pc4    = head_pc_q + 32'd4;
`ifdef IF_FETCH_ALIGN_CHECK_EN
  assign bus.misalign  = misalign_q;
`else
  assign bus.misalign  = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch
// Directed scenarios for reset, back-pressure, control-flow priority, eret on
// a full buffer, target alignment and mid-stream reset, followed by a
// randomized run checked against a queue-based fetch model.
module tb_if_fetch;
  logic clk = 1'b0;
  logic clrn;
  int   checks   = 0;
  int   failures = 0;

  if_fetch_if bus ();

  if_fetch #(.RESET_PC(32'h0000_0000), .EXC_VECTOR(32'h0000_0008)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  assign bus.imem_inst = mem_word(bus.imem_addr);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  task automatic idle_inputs();
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.exc         = 1'b0;
    bus.eret        = 1'b0;
    bus.epc         = 32'h0;
    bus.id_ready    = 1'b1;
  endtask

  // Leaves the bench at a falling edge with reset released; next rising edge fetches RESET_PC.
  task automatic apply_reset(input logic ready);
    idle_inputs();
    bus.id_ready = ready;
    @(negedge clk);
    clrn = 1'b0;
    @(negedge clk);
    clrn = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    clrn = 1'b1;
    #2 clrn = 1'b0;
    #1;
    checks++; if (bus.imem_addr !== 32'h0) begin failures++; $display("FAIL reset_imem_addr got=%h exp=%h", bus.imem_addr, 32'h0); end
    checks++; if (bus.id_valid !== 1'b0) begin failures++; $display("FAIL reset_id_valid got=%b exp=0", bus.id_valid); end
    checks++; if (bus.misalign !== 1'b0) begin failures++; $display("FAIL reset_misalign got=%b exp=0", bus.misalign); end
    @(negedge clk);
    clrn = 1'b1;
    checks++; if (bus.imem_addr !== 32'h0) begin failures++; $display("FAIL first_addr got=%h exp=%h", bus.imem_addr, 32'h0); end
    @(negedge clk);
    checks++; if (bus.imem_addr !== 32'h4) begin failures++; $display("FAIL second_addr got=%h exp=%h", bus.imem_addr, 32'h4); end
    checks++; if (bus.id_valid !== 1'b1) begin failures++; $display("FAIL first_valid got=%b exp=1", bus.id_valid); end
    checks++; if (bus.id_pc !== 32'h0) begin failures++; $display("FAIL first_id_pc got=%h exp=%h", bus.id_pc, 32'h0); end
    checks++; if (bus.id_pc4 !== 32'h4) begin failures++; $display("FAIL first_id_pc4 got=%h exp=%h", bus.id_pc4, 32'h4); end
    checks++; if (bus.id_inst !== mem_word(32'h0)) begin failures++; $display("FAIL first_id_inst got=%h exp=%h", bus.id_inst, mem_word(32'h0)); end
    @(negedge clk);
    checks++; if (bus.imem_addr !== 32'h8) begin failures++; $display("FAIL third_addr got=%h exp=%h", bus.imem_addr, 32'h8); end
    checks++; if (bus.id_pc !== 32'h4) begin failures++; $display("FAIL second_id_pc got=%h exp=%h", bus.id_pc, 32'h4); end
  endtask

  task automatic test_backpressure();
    apply_reset(1'b0);
    repeat (5) @(negedge clk);
    checks++; if (bus.imem_addr !== 32'h8) begin failures++; $display("FAIL bp_pc_hold got=%h exp=%h", bus.imem_addr, 32'h8); end
    checks++; if (bus.id_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b exp=1", bus.id_valid); end
    checks++; if (bus.id_pc !== 32'h0) begin failures++; $display("FAIL bp_head0 got=%h exp=%h", bus.id_pc, 32'h0); end
    bus.id_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++; if (bus.id_pc !== 32'(4 * i)) begin failures++; $display("FAIL bp_order[%0d] got=%h exp=%h", i, bus.id_pc, 32'(4 * i)); end
      checks++; if (bus.id_inst !== mem_word(32'(4 * i))) begin failures++; $display("FAIL bp_inst[%0d] got=%h exp=%h", i, bus.id_inst, mem_word(32'(4 * i))); end
    end
  endtask

  task automatic test_cf_priority();
    bus.exc = 1'b1; bus.eret = 1'b1; bus.redirect = 1'b1;
    bus.epc = 32'h8C; bus.redirect_pc = 32'h74;
    @(negedge clk);
    idle_inputs();
    checks++; if (bus.id_valid !== 1'b0) begin failures++; $display("FAIL prio_flush got=%b exp=0", bus.id_valid); end
    checks++; if (bus.imem_addr !== 32'h8) begin failures++; $display("FAIL prio_addr got=%h exp=%h", bus.imem_addr, 32'h8); end
    @(negedge clk);
    checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h8) begin failures++; $display("FAIL prio_head got=%b/%h exp=1/%h", bus.id_valid, bus.id_pc, 32'h8); end
  endtask

  task automatic test_eret_full();
    bus.id_ready = 1'b0;
    repeat (3) @(negedge clk);
    bus.eret = 1'b1; bus.epc = 32'h90; bus.id_ready = 1'b1;
    @(negedge clk);
    idle_inputs();
    checks++; if (bus.id_valid !== 1'b0) begin failures++; $display("FAIL eret_flush got=%b exp=0", bus.id_valid); end
    checks++; if (bus.imem_addr !== 32'h90) begin failures++; $display("FAIL eret_addr got=%h exp=%h", bus.imem_addr, 32'h90); end
    @(negedge clk);
    checks++; if (bus.id_pc !== 32'h90) begin failures++; $display("FAIL eret_head0 got=%h exp=%h", bus.id_pc, 32'h90); end
    @(negedge clk);
    checks++; if (bus.id_pc !== 32'h94) begin failures++; $display("FAIL eret_head1 got=%h exp=%h", bus.id_pc, 32'h94); end
  endtask

  task automatic test_misalign();
    bus.redirect = 1'b1; bus.redirect_pc = 32'h2E;
    @(negedge clk);
    idle_inputs();
`ifdef IF_FETCH_ALIGN_CHECK_EN
    checks++; if (bus.misalign !== 1'b1) begin failures++; $display("FAIL mis_set got=%b exp=1", bus.misalign); end
    repeat (3) @(negedge clk);
    checks++; if (bus.id_valid !== 1'b0 || bus.imem_addr !== 32'h2E) begin failures++; $display("FAIL mis_stall got=%b/%h exp=0/%h", bus.id_valid, bus.imem_addr, 32'h2E); end
    checks++; if (bus.misalign !== 1'b1) begin failures++; $display("FAIL mis_hold got=%b exp=1", bus.misalign); end
    bus.redirect = 1'b1; bus.redirect_pc = 32'h40;
    @(negedge clk);
    idle_inputs();
    checks++; if (bus.misalign !== 1'b0 || bus.imem_addr !== 32'h40) begin failures++; $display("FAIL mis_clear got=%b/%h exp=0/%h", bus.misalign, bus.imem_addr, 32'h40); end
    @(negedge clk);
    checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h40) begin failures++; $display("FAIL mis_fetch got=%b/%h exp=1/%h", bus.id_valid, bus.id_pc, 32'h40); end
`else
    checks++; if (bus.misalign !== 1'b0 || bus.imem_addr !== 32'h2C) begin failures++; $display("FAIL align_force got=%b/%h exp=0/%h", bus.misalign, bus.imem_addr, 32'h2C); end
    @(negedge clk);
    checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h2C) begin failures++; $display("FAIL align_fetch got=%b/%h exp=1/%h", bus.id_valid, bus.id_pc, 32'h2C); end
`endif
  endtask

  task automatic test_reset_midstream();
    bus.id_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.id_valid !== 1'b1) begin failures++; $display("FAIL mid_prefill got=%b exp=1", bus.id_valid); end
    #2 clrn = 1'b0;
    #1;
    checks++; if (bus.id_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", bus.id_valid); end
    checks++; if (bus.imem_addr !== 32'h0) begin failures++; $display("FAIL mid_addr got=%h exp=%h", bus.imem_addr, 32'h0); end
    @(negedge clk);
    clrn = 1'b1;
    bus.id_ready = 1'b1;
  endtask

  task automatic test_random();
    ent_t        q[$];
    logic [31:0] pc;
    logic        mis;
    logic [31:0] tgt;
    logic        deq, fetch;
    int          sel;
    apply_reset(1'b1);
    pc  = 32'h0;
    mis = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      checks++; if (bus.imem_addr !== pc) begin failures++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, bus.imem_addr, pc); end
      checks++; if (bus.id_valid !== (q.size() != 0)) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, bus.id_valid, q.size() != 0); end
      checks++; if (bus.misalign !== mis) begin failures++; $display("FAIL rnd_misalign cyc=%0d got=%b exp=%b", cyc, bus.misalign, mis); end
      if (q.size() != 0) begin
        checks++;
        if (bus.id_pc !== q[0].pc || bus.id_inst !== q[0].inst || bus.id_pc4 !== q[0].pc + 32'd4) begin
          failures++;
          $display("FAIL rnd_head cyc=%0d got=%h/%h/%h exp=%h/%h/%h", cyc, bus.id_pc, bus.id_inst, bus.id_pc4, q[0].pc, q[0].inst, q[0].pc + 32'd4);
        end
      end

      idle_inputs();
      bus.id_ready = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 15);
      if (sel == 0) bus.exc = 1'b1;
      if (sel <= 1) bus.eret = 1'b1;
      if (sel <= 3) bus.redirect = 1'b1;
      bus.epc = $urandom;
      bus.redirect_pc = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        bus.epc[1:0] = 2'b00;
        bus.redirect_pc[1:0] = 2'b00;
      end
      if ($urandom_range(0, 7) == 0) bus.redirect_pc = 32'hFFFF_FFF4;

      if (bus.exc || bus.eret || bus.redirect) begin
        tgt = bus.exc ? 32'h8 : (bus.eret ? bus.epc : bus.redirect_pc);
`ifdef IF_FETCH_ALIGN_CHECK_EN
        mis = (tgt % 4) != 0;
        pc  = tgt;
`else
        pc  = tgt - (tgt % 4);
`endif
        q.delete();
      end else begin
        deq   = (q.size() > 0) && bus.id_ready;
        fetch = !mis && ((q.size() < 2) || deq);
        if (deq) void'(q.pop_front());
        if (fetch) begin
          q.push_back('{pc: pc, inst: mem_word(pc)});
          pc = pc + 32'd4;
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_cf_priority();
    test_eret_full();
    test_misalign();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
